// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================
// Package : mul_arb_pkg
// Desc    : Shared types and defaults for the multiplier arbiter.
// Rev     : 1.0
// ============================================================
package mul_arb_pkg;

    localparam int c_DEF_WIDTH   = 32;
    localparam int c_DEF_MUL_LAT = 3;

    // Encoding 3 is unused; the arbiter recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_pipe.sv
`default_nettype none
// ============================================================
// Module : mul_pipe
// Desc   : Registered multiplier, MUL_LAT stages, valid pipe.
// Rev    : 1.0
// ============================================================
module mul_pipe
    import mul_arb_pkg::*;
#(
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int MUL_LAT = c_DEF_MUL_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] p
);

    logic [MUL_LAT-1:0] r_valid;
    logic [WIDTH-1:0]   r_prod [MUL_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= valid_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Data stages carry no reset; only the valid bits decide what is live.
    always_ff @(posedge clk) begin
        r_prod[0] <= a * b;
        for (int i = 1; i < MUL_LAT; i++) begin
            r_prod[i] <= r_prod[i-1];
        end
    end

    assign valid_out = r_valid[MUL_LAT-1];
    assign p         = r_prod[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================
// Module : mul_share_arbiter
// Desc   : Round-robin sharing of one pipelined multiplier.
// Rev    : 1.0
// ============================================================
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int MUL_LAT = c_DEF_MUL_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  busy
);

    localparam int c_IW = $clog2(NREQ);

    arb_state_t        r_state;
    logic [c_IW-1:0]   r_rr_ptr;
    logic [c_IW-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic [WIDTH-1:0]  r_result;
    logic              r_busy;

    logic [c_IW-1:0]   w_sel;
    logic              w_any;
    int                w_idx;
    logic              w_launch;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic              w_pvalid;
    logic [WIDTH-1:0]  w_p;

    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req[w_idx]) begin
                w_sel = c_IW'(w_idx);
                w_any = 1'b1;
            end
        end
    end

    // Operands are captured by the first pipe stage in the grant cycle.
    assign w_launch = (r_state == IDLE) && w_any;
    assign w_a      = op_a[int'(w_sel)*WIDTH +: WIDTH];
    assign w_b      = op_b[int'(w_sel)*WIDTH +: WIDTH];

    mul_pipe #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) u_mul_pipe (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (w_launch),
        .a         (w_a),
        .b         (w_b),
        .valid_out (w_pvalid),
        .p         (w_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_pvalid) begin
                        r_result <= w_p;
                        r_done   <= NREQ'(1) << r_grant;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_rr_ptr <= (r_grant == c_IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================
// Module : tb_mul_share_arbiter
// Desc   : Directed plus random checks against a timing model.
// Rev    : 1.0
// ============================================================
module tb_mul_share_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] op_a = '0;
    logic [NREQ*WIDTH-1:0] op_b = '0;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  busy;

    mul_share_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .op_a   (op_a),
        .op_b   (op_b),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: each grant occupies the unit for MUL_LAT+2 cycles,
    // done lands MUL_LAT+1 cycles after the grant cycle.
    int               cyc       = 0;
    int               free_at   = 0;
    int               launch_at = -1;
    int               done_at   = -1;
    int               m_gnt     = 0;
    int               m_rr      = 0;
    logic [WIDTH-1:0] m_res     = '0;
    logic [WIDTH-1:0] m_pend    = '0;
    logic [NREQ-1:0]  exp_done  = '0;
    logic             exp_busy  = 1'b0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_a[i*WIDTH +: WIDTH] = a;
        op_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic m_reset();
        free_at   = cyc;
        launch_at = -1;
        done_at   = -1;
        m_rr      = 0;
        m_res     = '0;
    endtask

    task automatic tick();
        longint unsigned pa;
        longint unsigned pb;
        longint unsigned pp;
        logic            found;
        if (cyc >= free_at && req != '0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[(m_rr + k) % NREQ]) begin
                    m_gnt = (m_rr + k) % NREQ;
                    found = 1'b1;
                end
            end
            pa        = longint'(op_a[m_gnt*WIDTH +: WIDTH]);
            pb        = longint'(op_b[m_gnt*WIDTH +: WIDTH]);
            pp        = pa * pb;
            m_pend    = pp[WIDTH-1:0];
            launch_at = cyc;
            done_at   = cyc + MUL_LAT + 1;
            free_at   = cyc + MUL_LAT + 2;
            m_rr      = (m_gnt + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_done = (cyc == done_at) ? (NREQ'(1) << m_gnt) : '0;
        if (cyc == done_at) m_res = m_pend;
        exp_busy = (launch_at >= 0) && (cyc > launch_at) && (cyc <= done_at);
        chk("model done", done, exp_done);
        chk("model busy", busy, exp_busy);
        chk("model result", result, m_res);
    endtask

    task automatic wait_done(input int idx, input logic [WIDTH-1:0] exp, input string tag, output int td);
        int n;
        n = 1;
        tick();
        while (done == '0 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " done"}, done, NREQ'(1) << idx);
        chk({tag, " result"}, result, exp);
        td = cyc;
    endtask

    initial begin
        int t0;
        int td;
        int tp;

        #2;
        chk("reset done", done, '0);
        chk("reset busy", busy, '0);
        chk("reset result", result, '0);

        // Full contention straight out of reset.
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10);
        req = '1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        tp = 0;
        for (int k = 0; k < NREQ; k++) begin
            wait_done(k, 10 * (k + 1), "contend", td);
            if (k > 0) chk("contend spacing", td - tp, MUL_LAT + 2);
            tp     = td;
            req[k] = 1'b0;
        end

        // Single request latency.
        tick();
        set_op(0, 2, 3);
        req = 4'b0001;
        t0  = cyc;
        wait_done(0, 6, "single", td);
        chk("single latency", td - t0, MUL_LAT + 1);
        req[0] = 1'b0;

        // Truncation on requester 2.
        set_op(2, 32'hFFFF_FFFF, 2);
        req = 4'b0100;
        wait_done(2, 32'hFFFF_FFFE, "trunc", td);
        req[2] = 1'b0;

        // Serve 3 so the pointer wraps to 0, then 0 beats 3.
        set_op(3, 3, 4);
        req = 4'b1000;
        wait_done(3, 12, "serve3", td);
        req[3] = 1'b0;
        tick();
        set_op(0, 11, 3);
        set_op(3, 13, 3);
        req = 4'b1001;
        wait_done(0, 33, "wrap first", td);
        req[0] = 1'b0;
        wait_done(3, 39, "wrap second", td);
        req[3] = 1'b0;

        // Pointer at 1 after serving 0: requester 3 goes before 0.
        set_op(0, 100, 100);
        req = 4'b0001;
        wait_done(0, 10000, "serve0", td);
        req[0] = 1'b0;
        tick();
        set_op(0, 21, 2);
        set_op(3, 17, 2);
        req = 4'b1001;
        wait_done(3, 34, "rr1 first", td);
        req[3] = 1'b0;
        wait_done(0, 42, "rr1 second", td);
        req[0] = 1'b0;

        // Held request on 1 yields to pending 2.
        set_op(1, 7, 8);
        set_op(2, 6, 6);
        req = 4'b0110;
        wait_done(1, 56, "held first", td);
        wait_done(2, 36, "held pending", td);
        req[2] = 1'b0;
        wait_done(1, 56, "held again", td);
        req[1] = 1'b0;

        // Reset two cycles into BUSY discards the operation.
        tick();
        set_op(0, 9, 9);
        req = 4'b0001;
        tick();
        tick();
        reset = 1'b1;
        req   = '0;
        #1;
        chk("midrst done", done, '0);
        chk("midrst busy", busy, '0);
        chk("midrst result", result, '0);
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("midrst hold done", done, '0);
        end
        reset = 1'b0;
        m_reset();
        set_op(1, 5, 7);
        req = 4'b0010;
        wait_done(1, 35, "after reset", td);
        req[1] = 1'b0;

        // Random traffic obeying the handshake.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 99) < 30) begin
                    if ($urandom_range(0, 1) == 1)
                        set_op(i, $urandom_range(0, 200), $urandom_range(0, 200));
                    else
                        set_op(i, $urandom, $urandom);
                    req[i] = 1'b1;
                end
            end
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (exp_done[i] && $urandom_range(0, 99) < 70) req[i] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
